// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed common-anode seven-segment driver with
//               per-digit enable, PWM brightness and frame-synchronous
//               double-buffered digit data.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 7,
    parameter int PRESCALE   = 100000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         brightness,
    input  logic                        load,
    output logic [SEG_W-1:0]            seven_seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic                        frame_tick
);

    localparam int c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_DATA_W = NUM_DIGITS * SEG_W;

    logic [c_PRE_W-1:0]    r_pre_cnt;
    logic [BRIGHT_W-1:0]   r_sub_cnt;
    logic [c_IDX_W-1:0]    r_digit_idx;
    logic [BRIGHT_W-1:0]   r_bright_act;

    logic [c_DATA_W-1:0]   r_pend_data;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [NUM_DIGITS-1:0] r_pend_en;
    logic                  r_pend_flag;
    logic [c_DATA_W-1:0]   r_act_data;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [NUM_DIGITS-1:0] r_act_en;

    logic                  w_pre_wrap;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [SEG_W-1:0]      w_seg_sel;
    logic                  w_dp_sel;
    logic                  w_en_sel;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic                  w_lit;

    always_comb begin
        w_pre_wrap  = (r_pre_cnt == c_PRE_W'(PRESCALE - 1));
        w_slot_end  = w_pre_wrap && (&r_sub_cnt);
        w_frame_end = w_slot_end && (r_digit_idx == c_IDX_W'(NUM_DIGITS - 1));
        w_seg_sel   = '0;
        w_dp_sel    = 1'b0;
        w_en_sel    = 1'b0;
        w_an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == c_IDX_W'(i)) begin
                w_seg_sel   = r_act_data[i*SEG_W +: SEG_W];
                w_dp_sel    = r_act_dp[i];
                w_en_sel    = r_act_en[i];
                w_an_sel[i] = 1'b0;
            end
        end
        w_lit = w_en_sel && (r_sub_cnt < r_bright_act);
    end

    // Scan counters: prescaler -> PWM sub-phase -> digit slot.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pre_cnt    <= '0;
            r_sub_cnt    <= '0;
            r_digit_idx  <= '0;
            r_bright_act <= '0;
        end else begin
            r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + 1'b1;
            if (w_pre_wrap)
                r_sub_cnt <= r_sub_cnt + 1'b1;
            if (w_slot_end) begin
                r_bright_act <= brightness;
                r_digit_idx  <= w_frame_end ? '0 : r_digit_idx + 1'b1;
            end
        end
    end

    // A load coinciding with the frame boundary bypasses the pending stage.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_pend_flag <= 1'b0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_en    <= '0;
        end else if (w_frame_end) begin
            if (load) begin
                r_act_data  <= digit_data;
                r_act_dp    <= dp_in;
                r_act_en    <= digit_en;
                r_pend_flag <= 1'b0;
            end else if (r_pend_flag) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_en    <= r_pend_en;
                r_pend_flag <= 1'b0;
            end
        end else if (load) begin
            r_pend_data <= digit_data;
            r_pend_dp   <= dp_in;
            r_pend_en   <= digit_en;
            r_pend_flag <= 1'b1;
        end
    end

    // Segments are blanked whenever the anode is off to prevent ghosting.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            AN         <= '1;
            seven_seg  <= '0;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame_end;
            if (w_lit) begin
                AN        <= w_an_sel;
                seven_seg <= w_seg_sel;
                dp        <= w_dp_sel;
            end else begin
                AN        <= '1;
                seven_seg <= '0;
                dp        <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Scoreboard bench for seg_scan_ctrl (4 digits, 8-clk slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SW = 7;
    localparam int PS = 2;
    localparam int BW = 2;
    localparam int FRAME = PS * (1 << BW) * ND;

    logic             clk_in = 1'b0;
    logic             rst;
    logic [ND*SW-1:0] digit_data;
    logic [ND-1:0]    dp_in;
    logic [ND-1:0]    digit_en;
    logic [BW-1:0]    brightness;
    logic             load;
    logic [SW-1:0]    seven_seg;
    logic             dp;
    logic [ND-1:0]    AN;
    logic             frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SEG_W      (SW),
        .PRESCALE   (PS),
        .BRIGHT_W   (BW)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .load       (load),
        .seven_seg  (seven_seg),
        .dp         (dp),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [SW-1:0] seg;
        logic          dp;
        logic          tick;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    int            k;
    logic [ND*SW-1:0] m_act_data, m_pend_data;
    logic [ND-1:0] m_act_dp, m_pend_dp, m_act_en, m_pend_en;
    logic          m_flag;
    logic [BW-1:0] m_bright;

    int          win_low [ND];
    logic [SW-1:0] last_seg [ND];
    int          win_dp, win_dp_bad, tick_seen, last_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_act_data = '0; m_pend_data = '0;
        m_act_dp = '0;   m_pend_dp = '0;
        m_act_en = '0;   m_pend_en = '0;
        m_flag = 1'b0;   m_bright = '0;
        last_tick = -1;
        sb.delete();
    endtask

    task automatic clr_win();
        for (int i = 0; i < ND; i++) begin
            win_low[i]  = 0;
            last_seg[i] = '0;
        end
        win_dp = 0; win_dp_bad = 0; tick_seen = 0;
    endtask

    // Predict the output produced by the counter state at cycle k, then advance one clock.
    task automatic step();
        int   pre, sub, idx;
        logic slot_end, frame_end, lit;
        exp_t e, got;
        pre = k % PS;
        sub = (k / PS) % (1 << BW);
        idx = (k / (PS * (1 << BW))) % ND;
        slot_end  = (pre == PS - 1) && (sub == (1 << BW) - 1);
        frame_end = slot_end && (idx == ND - 1);
        lit = m_act_en[idx] && (sub < int'(m_bright));
        e.an   = lit ? ~(ND'(1) << idx) : '1;
        e.seg  = lit ? m_act_data[idx*SW +: SW] : '0;
        e.dp   = lit ? m_act_dp[idx] : 1'b0;
        e.tick = frame_end;
        sb.push_back(e);
        if (slot_end) m_bright = brightness;
        if (frame_end) begin
            if (load) begin
                m_act_data = digit_data; m_act_dp = dp_in; m_act_en = digit_en;
                m_flag = 1'b0;
            end else if (m_flag) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
                m_flag = 1'b0;
            end
        end else if (load) begin
            m_pend_data = digit_data; m_pend_dp = dp_in; m_pend_en = digit_en;
            m_flag = 1'b1;
        end
        @(posedge clk_in);
        #1;
        k++;
        got = sb.pop_front();
        chk("an", AN, got.an);
        chk("seven_seg", seven_seg, got.seg);
        chk("dp", dp, got.dp);
        chk("frame_tick", frame_tick, got.tick);
        chk("an_onehot", ($countones(~AN) <= 1), 1);
        for (int i = 0; i < ND; i++) begin
            if (!AN[i]) begin
                win_low[i]++;
                last_seg[i] = seven_seg;
            end
        end
        if (dp) win_dp++;
        if (dp && AN != 4'b0111) win_dp_bad++;
        if (frame_tick) begin
            if (last_tick >= 0) chk("tick_period", k - last_tick, FRAME);
            last_tick = k;
            tick_seen++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic to_frame();
        while (k % FRAME != 0) step();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; digit_data = '0; dp_in = '0; digit_en = '0;
        brightness = '0; load = 1'b0;
        clr_win();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_an", AN, 4'hF);
        chk("rst_seg", seven_seg, 0);
        chk("rst_dp", dp, 0);
        chk("rst_tick", frame_tick, 0);
        rst = 1'b0;
        model_reset();

        // Full-brightness scan of four patterns
        digit_data = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        digit_en = 4'hF; brightness = 2'd3;
        pulse_load();
        to_frame();
        clr_win(); run(FRAME);
        for (int i = 0; i < ND; i++) chk("bright3_low", win_low[i], 6);
        chk("bright3_seg0", last_seg[0], 7'h3F);
        chk("bright3_seg3", last_seg[3], 7'h4F);
        chk("bright3_ticks", tick_seen, 1);

        // Asynchronous reset in the middle of a lit slot
        run(3);
        #3 rst = 1'b1;
        #1;
        chk("midrst_an", AN, 4'hF);
        chk("midrst_seg", seven_seg, 0);
        chk("midrst_dp", dp, 0);
        chk("midrst_tick", frame_tick, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        run(40);
        pulse_load();
        to_frame();

        // Brightness extremes
        brightness = 2'd0;
        run(FRAME);
        clr_win(); run(FRAME);
        for (int i = 0; i < ND; i++) chk("bright0_low", win_low[i], 0);
        brightness = 2'd1;
        run(FRAME);
        clr_win(); run(FRAME);
        for (int i = 0; i < ND; i++) chk("bright1_low", win_low[i], 2);

        // Enable mask
        brightness = 2'd3; digit_en = 4'b0101;
        pulse_load();
        to_frame();
        clr_win(); run(FRAME);
        chk("en_low0", win_low[0], 6);
        chk("en_low1", win_low[1], 0);
        chk("en_low2", win_low[2], 6);
        chk("en_low3", win_low[3], 0);

        // Tear-free update loaded during digit 2 slot
        digit_en = 4'hF;
        pulse_load();
        to_frame();
        run(16);
        digit_data = {7'h5E, 7'h39, 7'h7C, 7'h77};
        pulse_load();
        clr_win();
        to_frame();
        chk("tear_old2", last_seg[2], 7'h5B);
        chk("tear_old3", last_seg[3], 7'h4F);
        clr_win(); run(FRAME);
        chk("tear_new0", last_seg[0], 7'h77);
        chk("tear_new1", last_seg[1], 7'h7C);
        chk("tear_new2", last_seg[2], 7'h39);
        chk("tear_new3", last_seg[3], 7'h5E);

        // Load coincident with frame_end
        run(FRAME - 1);
        digit_data = {7'h6D, 7'h66, 7'h7D, 7'h07};
        pulse_load();
        clr_win(); run(FRAME);
        chk("coinc_seg0", last_seg[0], 7'h07);
        chk("coinc_seg3", last_seg[3], 7'h6D);

        // Decimal point on digit 3 only
        dp_in = 4'b1000;
        pulse_load();
        to_frame();
        clr_win(); run(FRAME);
        chk("dp_cycles", win_dp, 6);
        chk("dp_outside", win_dp_bad, 0);

        // Long random run
        clr_win();
        repeat (100 * FRAME) begin
            if ($urandom_range(0, 19) == 0) begin
                digit_data = (ND*SW)'($urandom);
                dp_in      = ND'($urandom);
                digit_en   = ND'($urandom);
                load       = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) brightness = BW'($urandom);
            step();
            load = 1'b0;
        end
        chk("rand_ticks", tick_seen, 100);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.
- Scans NUM_DIGITS digits at a programmable refresh rate and drives active-low anodes and a segment/decimal-point bus.
- Per-digit enable mask and PWM brightness control.
- Double-buffered digit data: updates take effect only at frame boundaries, so a frame never mixes old and new data.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes scanned; minimum 1.
- SEG_W, 7, segment bits per digit, excluding decimal point.
- PRESCALE, 100000, clk_in cycles per PWM sub-phase; minimum 1.
- BRIGHT_W, 3, brightness width; each digit slot has 2^BRIGHT_W sub-phases.

Ports:
- clk_in  in  1  system clock
- rst  in  1  asynchronous active-high reset
- digit_data  in  NUM_DIGITS*SEG_W  segment patterns, active-high; digit i at [i*SEG_W +: SEG_W]
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark
- brightness  in  BRIGHT_W  on-time in sub-phases; 0 = dark, max = (2^BRIGHT_W-1)/2^BRIGHT_W duty
- load  in  1  single-cycle strobe; captures digit_data, dp_in and digit_en into the pending buffer
- seven_seg  out  SEG_W  segment bus, active-high
- dp  out  1  decimal point, active-high
- AN  out  NUM_DIGITS  anode enables, active-low; at most one bit low at any time
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk_in.
- Reset values:
  - AN = all ones.
  - seven_seg = 0, dp = 0, frame_tick = 0.
  - All counters = 0.
  - Active and pending buffers = 0.
  - Pending flag cleared; active brightness = 0.
- Counters:
  - pre_cnt counts 0..PRESCALE-1 and wraps; pre_wrap = (pre_cnt == PRESCALE-1).
  - sub_cnt (BRIGHT_W bits) increments on pre_wrap.
  - slot_end = pre_wrap && sub_cnt all ones.
  - digit_idx counts 0..NUM_DIGITS-1, advances on slot_end, wraps to 0.
  - frame_end = slot_end && digit_idx == NUM_DIGITS-1.
  - PRESCALE=1 means pre_wrap is true every cycle.
- Output decode, registered (visible one clk_in after the counter state):
  - AN[i] = 0 iff i == digit_idx && en_act[i] && sub_cnt < bright_act; otherwise 1.
  - seven_seg/dp = active data of digit_idx when that digit is lit; 0 when not lit. This blanks segments whenever the anode is off, preventing ghosting.
- Disabled digits still occupy their slot (AN stays high), so the refresh rate is independent of digit_en.
- Brightness: bright_act samples brightness on every slot_end, so a change applies from the next slot.
- Double buffering:
  - load captures inputs into pending regs and sets the pending flag.
  - On frame_end with pending set: active <= pending, flag cleared.
  - load in the same cycle as frame_end: the newly presented inputs go directly to active and the flag stays clear.
  - Multiple loads within one frame: last one wins.
- frame_tick is registered, high the cycle after frame_end.
- rst mid-scan aborts immediately: outputs go to reset values asynchronously, buffered data is lost, and scanning restarts at digit 0, sub-phase 0.
- No combinational path from inputs to outputs.

Test Plan:
(Bench config for all cases: NUM_DIGITS=4, SEG_W=7, PRESCALE=2, BRIGHT_W=2; slot = 8 clk, frame = 32 clk.)
- Reset check: assert rst mid-slot -> AN=4'b1111, seven_seg=0, dp=0 in the same cycle. Release; load digits 0x3F,0x06,0x5B,0x4F, en=4'hF, brightness=3 -> after first frame_tick, AN sequence 1110,1101,1011,0111, each low 6 clk then high 2 clk, with matching seven_seg.
- Brightness extremes:
  - brightness=0 -> AN stays 4'b1111 and seven_seg=0 for a full frame.
  - brightness=1 -> each AN low exactly 2 clk per 8-clk slot.
- Enable mask: digit_en=4'b0101 -> only AN[0] and AN[2] ever go low; frame_tick period still 32 clk.
- Double-buffer tear-free:
  - load new data mid-frame (digit 2 slot) -> digits 2,3 keep old patterns until frame_tick; new patterns appear from digit 0 of the next frame.
  - load coincident with frame_end -> new data shown in the next frame.
- Decimal point: dp_in=4'b1000 -> dp=1 only while AN=0111 is low.
- Wrap and one-hot: run 100 frames with random loads -> AN never has more than one zero; digit_idx wraps 3->0; frame_tick is exactly 1 clk wide every 32 clk.
